// File: rtl/ysyx_pcu_pkg.sv
// Shared definitions for the PC unit: FSM state encoding and the default boot address.
`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif

package ysyx_pcu_pkg;

    typedef enum logic [1:0] {
        PCU_BOOT  = 2'd0,
        PCU_RUN   = 2'd1,
        PCU_DRAIN = 2'd2
    } pcu_state_e;

    localparam logic [31:0] PCU_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ysyx_pcu.sv
// PC unit: issues sequential fetch addresses with an outstanding-fetch limit,
// and handles writeback redirects by retagging the epoch and draining old fetches.
`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif

module ysyx_pcu
    import ysyx_pcu_pkg::*;
#(
    parameter int                XLEN     = `YSYX_XLEN,
    parameter logic [XLEN-1:0]   RESET_PC = XLEN'(PCU_RESET_PC),
    parameter int                MAX_OUT  = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            wbu_valid,
    input  logic            wbu_retire,
    input  logic [XLEN-1:0] wbu_npc,
    output logic [XLEN-1:0] out_pc,
    output logic            out_epoch,
    output logic            out_valid,
    input  logic            in_ready,
    input  logic            resp_valid,
    output logic            out_flush
);

    localparam logic [1:0] MAX_CNT = 2'(MAX_OUT);

    pcu_state_e      state_q, state_d;
    logic [XLEN-1:0] pc_q;
    logic            epoch_q;
    logic            flush_q;
    logic [1:0]      cnt_q, cnt_d;

    logic            handshake;
    logic            redirect;
    logic            resp_eff;
    logic [XLEN-1:0] npc_aligned;

    assign out_valid   = (state_q == PCU_RUN) && (cnt_q < MAX_CNT);
    assign handshake   = out_valid & in_ready;
    assign redirect    = wbu_valid & wbu_retire;
    // A response with nothing outstanding is stale (e.g. from before a reset).
    assign resp_eff    = resp_valid && (cnt_q != 2'd0);
    assign npc_aligned = wbu_npc & ~XLEN'(3);

    always_comb begin
        cnt_d = cnt_q;
        if (handshake && !resp_eff) begin
            cnt_d = cnt_q + 2'd1;
        end else if (!handshake && resp_eff) begin
            cnt_d = cnt_q - 2'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        if (redirect) begin
            state_d = (cnt_d != 2'd0) ? PCU_DRAIN : PCU_RUN;
        end else begin
            case (state_q)
                PCU_BOOT:  state_d = PCU_RUN;
                PCU_RUN:   state_d = PCU_RUN;
                PCU_DRAIN: state_d = (cnt_d == 2'd0) ? PCU_RUN : PCU_DRAIN;
                default:   state_d = PCU_BOOT;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= PCU_BOOT;
            pc_q    <= RESET_PC;
            epoch_q <= 1'b0;
            flush_q <= 1'b0;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            flush_q <= redirect;
            // Redirect wins over sequential advance; the coincident handshake is still counted.
            if (redirect) begin
                pc_q    <= npc_aligned;
                epoch_q <= ~epoch_q;
            end else if (handshake) begin
                pc_q    <= pc_q + XLEN'(4);
            end
        end
    end

    assign out_pc    = pc_q;
    assign out_epoch = epoch_q;
    assign out_flush = flush_q;

endmodule
